// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, block width, controller states,
// the forward S-box table and the GF(2^8) doubling helper.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } aes_state_e;

    // Forward S-box, entry 0 in the leftmost position.
    localparam logic [0:255][7:0] AES_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: current round key and rcon -> next round key.
module aes_key_step (
    input  logic [127:0] rkey,
    input  logic [7:0]   rcon,
    output logic [127:0] rkey_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, sub;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rkey;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .a (rot[8*i +: 8]),
            .y (sub[8*i +: 8])
        );
    end

    assign n0 = w0 ^ sub ^ {rcon, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rkey_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_mixcolumns.sv
// MixColumns: multiplies each state column by the fixed {02,03,01,01} circulant.
module aes_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];

        assign dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_sbox.sv
// Single-byte forward S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    assign y = AES_SBOX[a];

endmodule

// File: rtl/aes_shiftrows.sv
// shiftrows: row r of the column-major state rotates left by r bytes.
module aes_shiftrows (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/aes_subbytes.sv
// SubBytes: applies the S-box to each of the 16 state bytes.
module aes_subbytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        aes_sbox u_sbox (
            .a (din[127-8*i -: 8]),
            .y (dout[127-8*i -: 8])
        );
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys
// expanded on the fly, valid/ready handshakes on both job input and result.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int BLK_W = AES_BLK_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] plaintext,
    input  logic [BLK_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] ciphertext,
    output logic             busy
);

    if (NR != 10 || BLK_W != 128) begin : g_cfg_check
        $error("aes_round_ctrl supports only NR=10 and BLK_W=128");
    end

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends on valid, and valid is held with its
    // data stable until the transfer completes.
    aes_state_e       fsm_q, fsm_d;
    logic [3:0]       round_q, round_d;
    logic [127:0]     state_q, state_d;
    logic [127:0]     rkey_q, rkey_d;
    logic [7:0]       rcon_q, rcon_d;

    logic [127:0]     sb, sr, mc, rkey_next, round_out;

    aes_subbytes   u_subbytes   (.din(state_q), .dout(sb));
    aes_shiftrows  u_shiftrows  (.din(sb),      .dout(sr));
    aes_mixcolumns u_mixcolumns (.din(sr),      .dout(mc));

    aes_key_step u_key_step (
        .rkey      (rkey_q),
        .rcon      (rcon_q),
        .rkey_next (rkey_next)
    );

    // The final round has no MixColumns.
    assign round_out = ((round_q == LAST_ROUND) ? sr : mc) ^ rkey_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
            rkey_q  <= '0;
            rcon_q  <= 8'h01;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        rkey_d     = rkey_q;
        rcon_d     = rcon_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        ciphertext = '0;

        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rkey_d  = key;
                    round_d = 4'd1;
                    rcon_d  = 8'h01;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                state_d = round_out;
                rkey_d  = rkey_next;
                rcon_d  = xtime(rcon_q);
                // The counter parks at the last round instead of wrapping.
                if (round_q == LAST_ROUND) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                ciphertext = state_q;
                if (out_ready) begin
                    round_d = '0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: known-answer vectors from a table plus
// hand-written sequences for backpressure, busy rejection, reset and streaming.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] ciphertext;

    int checks = 0;
    int passed = 0;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           bp;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Runs one job from an idle bench; optionally offers a second vector
    // mid-RUN, and holds the result back for bp cycles before taking it.
    task automatic run_job(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] ct, input int bp, input bit inject,
                           input logic [127:0] ipt, input logic [127:0] ik,
                           input string tag);
        int  n;
        bit  ok;
        logic [127:0] exp;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check({tag, " ready_wait"}, 128'(ok), 128'd1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        exp_q.push_back(ct);
        @(negedge clk);
        in_valid  = 1'b0;
        plaintext = ~pt;
        key       = ~k;
        check({tag, " busy_after_accept"}, 128'(busy), 128'd1);
        check({tag, " in_ready_after_accept"}, 128'(in_ready), 128'd0);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 40) begin
            if (inject && n == 3) begin
                check({tag, " in_ready_while_run"}, 128'(in_ready), 128'd0);
                plaintext = ipt;
                key       = ik;
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (n == 5 || n == 6);
            @(negedge clk);
            n++;
            if (out_valid) ok = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, " latency"}, 128'(n), 128'd10);
        exp = exp_q.pop_front();
        check({tag, " ct"}, ciphertext, exp);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, " bp_out_valid"}, 128'(out_valid), 128'd1);
            check({tag, " bp_ct"}, ciphertext, exp);
            check({tag, " bp_busy"}, 128'(busy), 128'd1);
            check({tag, " bp_in_ready"}, 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid_drop"}, 128'(out_valid), 128'd0);
        check({tag, " idle_in_ready"}, 128'(in_ready), 128'd1);
        check({tag, " idle_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit leaked;
        int j, outs, last_c, overlap;

        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32, 0};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 2};

        // Reset values.
        #1;
        check("rst in_ready", 128'(in_ready), 128'd1);
        check("rst out_valid", 128'(out_valid), 128'd0);
        check("rst busy", 128'(busy), 128'd0);
        check("rst ciphertext", ciphertext, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Known-answer table, each with its own backpressure length.
        for (int i = 0; i < 3; i++) begin
            run_job(vecs[i].pt, vecs[i].key, vecs[i].ct, vecs[i].bp, 1'b0, '0, '0,
                    $sformatf("vec%0d", i));
        end

        // A second job offered during RUN is dropped, then accepted later.
        run_job(vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 1'b1, vecs[1].pt, vecs[1].key, "busy_rej");
        run_job(vecs[1].pt, vecs[1].key, vecs[1].ct, 0, 1'b0, '0, '0, "after_rej");

        // Reset in the middle of RUN discards the job.
        @(negedge clk);
        plaintext = vecs[0].pt;
        key       = vecs[0].key;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst in_ready", 128'(in_ready), 128'd1);
        check("midrst out_valid", 128'(out_valid), 128'd0);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst ciphertext", ciphertext, 128'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        leaked = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        check("midrst no_leak", 128'(leaked), 128'd0);
        run_job(vecs[0].pt, vecs[0].key, vecs[0].ct, 0, 1'b0, '0, '0, "post_rst");

        // Streaming: in_valid and out_ready held high for three jobs.
        j       = 0;
        outs    = 0;
        last_c  = 0;
        overlap = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && outs < 3; c++) begin
            @(negedge clk);
            if (in_ready && out_valid) overlap++;
            if (out_valid) begin
                check($sformatf("b2b ct%0d", outs), ciphertext, exp_q.pop_front());
                if (outs > 0) check($sformatf("b2b period%0d", outs), 128'(c - last_c), 128'd12);
                last_c = c;
                outs++;
            end
            if (in_ready) begin
                if (j < 3) begin
                    plaintext = vecs[j].pt;
                    key       = vecs[j].key;
                    in_valid  = 1'b1;
                    exp_q.push_back(vecs[j].ct);
                    j++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b jobs_done", 128'(outs), 128'd3);
        check("b2b no_overlap", 128'(overlap), 128'd0);
        check("b2b idle", 128'(in_ready), 128'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
